pipe_skid_reg: RTL and testbench

Parametrised pipeline register with valid/ready handshake and a one-entry skid buffer, placed between processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces plain per-bit flip-flops with a full-throughput stage that supports backpressure (stall) and flush (bubble insertion). `in_ready` is registered, so stall signals do not form a combinational path across stages.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_sat_counter.sv | 50 +++++
 rtl/pipe_skid_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipe_skid_reg pipeline
//                stage: the stage state encoding and the width of the
//                optional performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // EMPTY: nothing held; BUSY: main register full; FULL: main + skid full.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam int unsigned PERF_CNT_W = 16;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// ============================================================================
//  Module      : pipe_sat_counter
//  Description : Saturating up-counter. When inc is high the counter adds amt
//                (0..3) and clamps at all-ones instead of wrapping.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous active-high reset, clears the count
//                inc   - enable an increment this cycle
//                amt   - increment amount
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic [1:0]   amt,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum;

    // One extra bit catches the carry so saturation needs no compare.
    assign sum = {1'b0, count_q} + {{(W - 1){1'b0}}, amt};

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_sat_counter

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Pipeline register with valid/ready handshake and a one-entry
//                skid buffer. in_ready is registered so downstream stalls do
//                not ripple combinationally upstream. flush discards all held
//                entries; rst additionally clears the performance counters.
//  Ports       : clk, rst            - clock / synchronous active-high reset
//                flush               - discard held entries (bubble insert)
//                in_valid/in_ready   - upstream handshake, in_data payload
//                out_valid/out_ready - downstream handshake, out_data payload
//                stall_cycles        - (PIPE_SKID_PERF_EN) cycles stalled
//                flush_drops         - (PIPE_SKID_PERF_EN) entries flushed
//  Config      : define PIPE_SKID_PERF_EN to add the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_drops
`endif
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Input offered this cycle is dropped; a downstream transfer
            // still completes because out_data is valid until the edge.
            state_d = EMPTY;
            main_d  = RESET_VALUE;
            skid_d  = RESET_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        // in_ready only drops next cycle, so this word is
                        // parked in the skid register.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VALUE;
            skid_q     <= RESET_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [1:0] drop_amt;

    // Number of valid entries discarded if flush is taken this cycle.
    assign drop_amt = (state_q == FULL) ? 2'd2 :
                      (state_q == BUSY) ? 2'd1 : 2'd0;

    pipe_sat_counter #(
        .W (PERF_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .amt   (2'd1),
        .count (stall_cycles)
    );

    pipe_sat_counter #(
        .W (PERF_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .amt   (drop_amt),
        .count (flush_drops)
    );
`endif

endmodule : pipe_skid_reg

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Self-checking bench for pipe_skid_reg (WIDTH=8,
//                RESET_VALUE=8'h5A). Define PIPE_SKID_PERF_EN to also cover
//                the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    localparam int unsigned W  = 8;
    localparam logic [W-1:0] RV = 8'h5A;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [15:0]  stall_cycles;
    logic [15:0]  flush_drops;
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [W-1:0] m_q[$];
    logic [15:0]  m_stall = '0;
    logic [15:0]  m_drops = '0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl = 1'b0, input logic r = 1'b0);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples mid-cycle, compares against queued words,
    // then advances the expected contents for the coming edge.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            chk("mon_in_ready", in_ready, (m_q.size() < 2));
            chk("mon_out_valid", out_valid, (m_q.size() > 0));
            if (out_valid && m_q.size() > 0) begin
                chk(out_ready ? "mon_out_data_xfer" : "mon_out_data_hold", out_data, m_q[0]);
            end
`ifdef PIPE_SKID_PERF_EN
            chk("mon_stall_cycles", stall_cycles, m_stall);
            chk("mon_flush_drops", flush_drops, m_drops);
`endif
            if (rst) begin
                m_q.delete();
                m_stall = '0;
                m_drops = '0;
            end else begin
                if (m_q.size() > 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
                if (flush) begin
                    if (32'(m_drops) + m_q.size() > 32'hFFFF) m_drops = 16'hFFFF;
                    else m_drops = m_drops + 16'(m_q.size());
                    m_q.delete();
                end else begin
                    bit in_x;
                    in_x = in_valid && (m_q.size() < 2);
                    if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
                    if (in_x) m_q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, RV);

        // Streaming
        cyc(1'b1, 8'h11, 1'b1);
        chk("stream_0", {in_ready, out_valid, out_data}, {1'b1, 1'b1, 8'h11});
        cyc(1'b1, 8'h22, 1'b1);
        chk("stream_1", {in_ready, out_valid, out_data}, {1'b1, 1'b1, 8'h22});
        cyc(1'b1, 8'h33, 1'b1);
        chk("stream_2", {in_ready, out_valid, out_data}, {1'b1, 1'b1, 8'h33});
        cyc(1'b0, '0, 1'b1);
        chk("stream_end_valid", out_valid, 1'b0);

        // Backpressure
        cyc(1'b1, 8'h0A, 1'b0);
        chk("bp_busy", {in_ready, out_valid, out_data}, {1'b1, 1'b1, 8'h0A});
        cyc(1'b1, 8'h0B, 1'b0);
        chk("bp_full", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 8'h0A});
        cyc(1'b1, 8'h0C, 1'b0);
        chk("bp_full_hold", {in_ready, out_valid, out_data}, {1'b0, 1'b1, 8'h0A});
        cyc(1'b0, '0, 1'b1);
        chk("bp_drain_0", {in_ready, out_valid, out_data}, {1'b1, 1'b1, 8'h0B});
        cyc(1'b0, '0, 1'b1);
        chk("bp_drain_1", out_valid, 1'b0);

        // Flush in FULL with an input offered
        cyc(1'b1, 8'h0A, 1'b0);
        cyc(1'b1, 8'h0B, 1'b0);
        chk("fl_pre_full", in_ready, 1'b0);
        cyc(1'b1, 8'h0C, 1'b0, 1'b1);
        chk("fl_after", {in_ready, out_valid, out_data}, {1'b1, 1'b0, RV});
`ifdef PIPE_SKID_PERF_EN
        chk("fl_drops", flush_drops, 16'd2);
`endif
        cyc(1'b0, '0, 1'b1);
        chk("fl_no_0C", out_valid, 1'b0);

        // Flush in BUSY while downstream takes the word
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("fl_busy_after", {in_ready, out_valid}, {1'b1, 1'b0});

        // Reset mid-operation
        cyc(1'b1, 8'h55, 1'b0);
        chk("rst_pre_busy", {out_valid, out_data}, {1'b1, 8'h55});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid", {in_ready, out_valid, out_data}, {1'b1, 1'b0, RV});
`ifdef PIPE_SKID_PERF_EN
        chk("rst_mid_stall_cnt", stall_cycles, 16'd0);
`endif

        // Flush and reset together: reset wins
        cyc(1'b1, 8'h66, 1'b0);
        cyc(1'b1, 8'h67, 1'b0, 1'b1, 1'b1);
        chk("rst_flush", {in_ready, out_valid, out_data}, {1'b1, 1'b0, RV});

        // Random handshake traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 511) == 0));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        chk("rand_drained", out_valid, 1'b0);

`ifdef PIPE_SKID_PERF_EN
        // Stall counter saturation
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 70000; i++) cyc(1'b0, '0, 1'b0);
        chk("sat_stall", stall_cycles, 16'hFFFF);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_skid_reg

`default_nettype wire
